// File: rtl/ysyx_25030081_rf_wb_arb_if.sv
// ysyx_25030081_rf_wb_arb_if: writeback/issue handshakes, hazard query and RF write port bundle
interface ysyx_25030081_rf_wb_arb_if #(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic exu_valid, exu_ready;
  logic [RF_ADDR_WIDTH-1:0] exu_rd;
  logic [DATA_WIDTH-1:0] exu_data;
  logic lsu_valid, lsu_ready;
  logic [RF_ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;
  logic iss_valid, iss_ready;
  logic [RF_ADDR_WIDTH-1:0] iss_rd;
  logic [RF_ADDR_WIDTH-1:0] rs1, rs2;
  logic rs1_busy, rs2_busy;
  logic rf_wen;
  logic [RF_ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic rs1_fwd, rs2_fwd;
  logic [DATA_WIDTH-1:0] rs1_fwd_data, rs2_fwd_data;
  logic wb_err;
  modport slave (
    input exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data, iss_valid, iss_rd, rs1, rs2,
    output exu_ready, lsu_ready, iss_ready, rs1_busy, rs2_busy, rf_wen, rf_waddr, rf_wdata,
    output rs1_fwd, rs2_fwd, rs1_fwd_data, rs2_fwd_data, wb_err
  );
  modport master (
    output exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data, iss_valid, iss_rd, rs1, rs2,
    input exu_ready, lsu_ready, iss_ready, rs1_busy, rs2_busy, rf_wen, rf_waddr, rf_wdata,
    input rs1_fwd, rs2_fwd, rs1_fwd_data, rs2_fwd_data, wb_err
  );
endinterface

// File: rtl/ysyx_25030081_rf_wb_arb.sv
// ysyx_25030081_rf_wb_arb: EXU/LSU writeback arbiter with pending-write scoreboard; YSYX_25030081_WB_BYPASS_EN enables commit-cycle bypass
module ysyx_25030081_rf_wb_arb #(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  ysyx_25030081_rf_wb_arb_if.slave wb
);
  localparam int NREG = 1 << RF_ADDR_WIDTH;
  logic prio;
  logic [1:0] cnt [NREG];
  logic [NREG-1:0] inc, dec;
  logic exu_g, lsu_g, iss_hs, byp1, byp2;
  logic [RF_ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  assign exu_g = !rst && wb.exu_valid && (!wb.lsu_valid || !prio);
  assign lsu_g = !rst && wb.lsu_valid && (!wb.exu_valid || prio);
  assign wb.exu_ready = exu_g;
  assign wb.lsu_ready = lsu_g;
  assign wb.iss_ready = !rst && (wb.iss_rd == '0 || cnt[wb.iss_rd] != 2'd3);
  assign iss_hs = wb.iss_valid && wb.iss_ready && wb.iss_rd != '0;
  assign wb_rd = lsu_g ? wb.lsu_rd : wb.exu_rd;
  assign wb_data = lsu_g ? wb.lsu_data : wb.exu_data;
`ifdef YSYX_25030081_WB_BYPASS_EN
  assign byp1 = wb.rf_wen && wb.rf_waddr == wb.rs1 && wb.rs1 != '0 && cnt[wb.rs1] == 2'd1;
  assign byp2 = wb.rf_wen && wb.rf_waddr == wb.rs2 && wb.rs2 != '0 && cnt[wb.rs2] == 2'd1;
  assign wb.rs1_fwd_data = byp1 ? wb.rf_wdata : '0;
  assign wb.rs2_fwd_data = byp2 ? wb.rf_wdata : '0;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
  assign wb.rs1_fwd_data = '0;
  assign wb.rs2_fwd_data = '0;
`endif
  assign wb.rs1_fwd = byp1;
  assign wb.rs2_fwd = byp2;
  assign wb.rs1_busy = wb.rs1 != '0 && cnt[wb.rs1] != 2'd0 && !byp1;
  assign wb.rs2_busy = wb.rs2 != '0 && cnt[wb.rs2] != 2'd0 && !byp2;
  // per-register issue (increment) and commit (decrement) strobes; x0 never gets either
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NREG; i++) begin
      inc[i] = iss_hs && wb.iss_rd == RF_ADDR_WIDTH'(i);
      dec[i] = wb.rf_wen && wb.rf_waddr == RF_ADDR_WIDTH'(i);
    end
  end
  // round-robin pointer, registered write port, pending counters and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
      wb.rf_wen <= 1'b0;
      wb.rf_waddr <= '0;
      wb.rf_wdata <= '0;
      wb.wb_err <= 1'b0;
      for (int i = 0; i < NREG; i++) cnt[i] <= 2'd0;
    end else begin
      if (wb.exu_valid && wb.lsu_valid) prio <= !prio;
      wb.rf_wen <= (exu_g || lsu_g) && wb_rd != '0;
      wb.rf_waddr <= wb_rd;
      wb.rf_wdata <= wb_data;
      wb.wb_err <= wb.wb_err || (wb.rf_wen && cnt[wb.rf_waddr] == 2'd0);
      for (int i = 0; i < NREG; i++)
        cnt[i] <= (inc[i] && !dec[i]) ? cnt[i] + 2'd1 :
                  (dec[i] && !inc[i] && cnt[i] != 2'd0) ? cnt[i] - 2'd1 : cnt[i];
    end
  end
endmodule
